// File: rtl/magnitude_pkg.sv
// Shared types for the FFT magnitude scheduler.
// Beat bin field covers frames of up to 256 bins.
package magnitude_pkg;

  localparam int DEF_FFT_DATA_WIDTH = 16;
  localparam int DEF_MEL_DATA_WIDTH = 32;
  localparam int MAX_BIN_W          = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } mag_sched_state_t;

  typedef struct packed {
    logic [DEF_MEL_DATA_WIDTH-1:0] data;
    logic [MAX_BIN_W-1:0]          bin;
    logic                          last;
  } mag_beat_t;

endpackage

// File: rtl/magnitude_scheduler_if.sv
// Result stream toward the mel filterbank.
// Master drives valid/data/bin/last, slave drives ready.
interface magnitude_scheduler_if #(
  parameter int DW = 32,
  parameter int BW = 8
);

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [BW-1:0] out_bin;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_bin,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_bin,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/mag_result_fifo.sv
// Sync FIFO of magnitude beats; head is read straight from
// the storage registers so it holds while not popped.
module mag_result_fifo
  import magnitude_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  mag_beat_t     i_beat,
  input  logic          i_pop,
  output mag_beat_t     o_head,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  mag_beat_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_pop   = i_pop && (r_cnt != '0);
  assign w_push  = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);
  assign o_head  = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_beat;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/magnitude_scheduler.sv
// Walks one FFT frame through the external magnitude unit
// and streams per-bin results to the mel stage.
module magnitude_scheduler
  import magnitude_pkg::*;
#(
  parameter  int FFT_DATA_WIDTH = DEF_FFT_DATA_WIDTH,
  parameter  int MEL_DATA_WIDTH = DEF_MEL_DATA_WIDTH,
  parameter  int N_BINS         = 256,
  parameter  int MAG_LATENCY    = 1,
  parameter  int FIFO_DEPTH     = 4,
  localparam int BW             = $clog2(N_BINS),
  localparam int CW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      fft_rd_en,
  output logic [BW-1:0]             fft_addr,
  input  logic [FFT_DATA_WIDTH-1:0] fft_real,
  input  logic [FFT_DATA_WIDTH-1:0] fft_imag,
  output logic [FFT_DATA_WIDTH-1:0] mag_real,
  output logic [FFT_DATA_WIDTH-1:0] mag_imag,
  input  logic [MEL_DATA_WIDTH-1:0] mag_result,
  magnitude_scheduler_if.master     out_if
);

  mag_sched_state_t          r_state;
  logic                      r_busy;
  logic                      r_done;
  logic [BW-1:0]             r_addr;
  logic                      r_s0_v;
  logic [BW-1:0]             r_s0_bin;
  logic [FFT_DATA_WIDTH-1:0] r_mag_real;
  logic [FFT_DATA_WIDTH-1:0] r_mag_imag;
  logic [MAG_LATENCY:0]      r_pv;
  logic [BW-1:0]             r_pb [MAG_LATENCY+1];

  mag_beat_t                 w_beat;
  mag_beat_t                 w_head;
  logic                      w_empty;
  logic [CW-1:0]             w_cnt;
  logic                      w_pop;
  logic                      w_push;
  int                        w_inflight;
  logic                      w_credit_ok;
  logic                      w_last_issue;
  logic                      w_pipe_empty;
  logic                      w_fifo_drains;

  assign busy      = r_busy;
  assign done      = r_done;
  assign fft_addr  = r_addr;
  assign mag_real  = r_mag_real;
  assign mag_imag  = r_mag_imag;

  assign out_if.out_valid = !w_empty;
  assign out_if.out_data  = w_head.data;
  assign out_if.out_bin   = w_head.bin[BW-1:0];
  assign out_if.out_last  = w_head.last;

  assign w_pop  = out_if.out_valid && out_if.out_ready;
  assign w_push = r_pv[MAG_LATENCY];

  always_comb begin
    w_beat      = '0;
    w_beat.data = mag_result;
    w_beat.bin  = MAX_BIN_W'(r_pb[MAG_LATENCY]);
    w_beat.last = (r_pb[MAG_LATENCY] == BW'(N_BINS - 1));
  end

  // Every read already issued will land in the FIFO even if the
  // mel stage stalls forever, so reserve a slot for each one.
  always_comb begin
    w_inflight = int'(r_s0_v);
    for (int k = 0; k <= MAG_LATENCY; k++)
      w_inflight += int'(r_pv[k]);
  end

  assign w_credit_ok  = (int'(w_cnt) - int'(w_pop) + w_inflight)
                        < FIFO_DEPTH;
  assign fft_rd_en    = (r_state == RUN) && w_credit_ok;
  assign w_last_issue = (r_addr == BW'(N_BINS - 1));
  assign w_pipe_empty = !r_s0_v && (r_pv == '0);
  assign w_fifo_drains = w_empty || ((w_cnt == CW'(1)) && w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_addr  <= '0;
          end
        end
        RUN: begin
          if (fft_rd_en) begin
            if (w_last_issue) r_state <= DRAIN;
            else              r_addr  <= r_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (w_pipe_empty && w_fifo_drains) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag pipe: s0 is the RAM data cycle, pv[0] the operand
  // cycle, pv[MAG_LATENCY] the cycle mag_result is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_v     <= 1'b0;
      r_s0_bin   <= '0;
      r_mag_real <= '0;
      r_mag_imag <= '0;
      r_pv       <= '0;
      for (int k = 0; k <= MAG_LATENCY; k++) r_pb[k] <= '0;
    end else begin
      r_s0_v   <= fft_rd_en;
      r_s0_bin <= r_addr;
      if (r_s0_v) begin
        r_mag_real <= fft_real;
        r_mag_imag <= fft_imag;
      end
      r_pv[0] <= r_s0_v;
      r_pb[0] <= r_s0_bin;
      for (int k = 1; k <= MAG_LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pb[k] <= r_pb[k-1];
      end
    end
  end

  mag_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_beat  (w_beat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

endmodule

// File: tb/tb_magnitude_scheduler.sv
// Bench for magnitude_scheduler: 4-bin directed frames and a
// 256-bin random-backpressure run, both scoreboarded.
module tb_magnitude_scheduler;

  localparam int NB   = 4;
  localparam int BW   = 2;
  localparam int NB2  = 256;
  localparam int BW2  = 8;
  localparam int FDEP = 4;

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [31:0] mag;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          bin;
    bit          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] isqrt(input longint v);
    longint r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return 32'(r);
  endfunction

  // ---------------- 4-bin instance ----------------
  logic          rst4, start4, busy4, done4, rd4;
  logic [BW-1:0] addr4;
  logic [15:0]   fre4, fim4, mre4, mim4;
  logic [31:0]   mres4;
  vec_t          tbl [NB];

  magnitude_scheduler_if #(.DW(32), .BW(BW)) o4();

  magnitude_scheduler #(.N_BINS(NB), .FIFO_DEPTH(FDEP)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .busy(busy4),
    .done(done4), .fft_rd_en(rd4), .fft_addr(addr4),
    .fft_real(fre4), .fft_imag(fim4), .mag_real(mre4),
    .mag_imag(mim4), .mag_result(mres4), .out_if(o4)
  );

  always @(posedge clk) if (rd4) begin
    fre4 <= tbl[addr4].re;
    fim4 <= tbl[addr4].im;
  end
  always @(posedge clk)
    mres4 <= isqrt(longint'(mre4) * mre4 + longint'(mim4) * mim4);

  exp_t q4[$];
  int   beats4 = 0, dones4 = 0, rds4 = 0, cyc = 0;
  int   first4 = 0, last4c = 0, done4c = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst4 === 1'b1 && rd4 === 1'b1) rds4++;
    if (rst4 === 1'b1 && o4.out_valid === 1'b1 && o4.out_ready) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat4_extra: got bin %0d, want none", o4.out_bin);
      end else begin
        e = q4.pop_front();
        chk("beat4_data", o4.out_data, e.data);
        chk("beat4_bin", o4.out_bin, e.bin);
        chk("beat4_last", o4.out_last, e.last);
      end
      if (o4.out_bin == 0) first4 = cyc;
      if (o4.out_last) last4c = cyc;
      beats4++;
    end
    if (rst4 === 1'b1 && done4 === 1'b1) begin
      dones4++;
      done4c = cyc;
    end
  end

  task automatic push_frame4();
    for (int i = 0; i < NB; i++)
      q4.push_back('{data: tbl[i].mag, bin: i, last: (i == NB - 1)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic wait_done4(input int budget, output bit ok,
                            output logic b);
    ok = 1'b0;
    b  = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done4) begin
        ok = 1'b1;
        b  = busy4;
      end
    end
    #1;
  endtask

  // ---------------- 256-bin instance ----------------
  logic           rst256, start256, busy256, done256, rd256;
  logic [BW2-1:0] addr256;
  logic [15:0]    fre256, fim256, mre256, mim256;
  logic [31:0]    mres256;

  magnitude_scheduler_if #(.DW(32), .BW(BW2)) o256();

  magnitude_scheduler #(.N_BINS(NB2), .FIFO_DEPTH(FDEP)) dut256 (
    .clk(clk), .rst(rst256), .start(start256), .busy(busy256),
    .done(done256), .fft_rd_en(rd256), .fft_addr(addr256),
    .fft_real(fre256), .fft_imag(fim256), .mag_real(mre256),
    .mag_imag(mim256), .mag_result(mres256), .out_if(o256)
  );

  always @(posedge clk) if (rd256) begin
    fre256 <= 16'(int'(addr256) * 3);
    fim256 <= 16'(int'(addr256) * 4);
  end
  always @(posedge clk)
    mres256 <= isqrt(longint'(mre256) * mre256 + longint'(mim256) * mim256);

  exp_t q256[$];
  int   beats256 = 0, dones256 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst256 === 1'b1 && o256.out_valid === 1'b1 && o256.out_ready) begin
      if (q256.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat256_extra: got bin %0d, want none", o256.out_bin);
      end else begin
        e = q256.pop_front();
        chk("beat256_data", o256.out_data, e.data);
        chk("beat256_bin", o256.out_bin, e.bin);
        chk("beat256_last", o256.out_last, e.last);
      end
      beats256++;
    end
    if (rst256 === 1'b1 && done256 === 1'b1) dones256++;
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          ok, ok2;
    logic        b;
    int          d0, b0, r0;
    bit          stable;
    logic [31:0] hd;
    logic [BW-1:0] hb;

    tbl[0] = '{16'd3, 16'd4, 32'd5};
    tbl[1] = '{16'd5, 16'd12, 32'd13};
    tbl[2] = '{16'd8, 16'd15, 32'd17};
    tbl[3] = '{16'd0, 16'd0, 32'd0};

    rst4 = 1'b0; rst256 = 1'b0;
    start4 = 1'b0; start256 = 1'b0;
    o4.out_ready = 1'b1; o256.out_ready = 1'b1;
    repeat (3) tick();

    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_rd_en", rd4, 0);
    chk("rst_addr", addr4, 0);
    chk("rst_valid", o4.out_valid, 0);
    chk("rst_last", o4.out_last, 0);
    chk("rst_data", o4.out_data, 0);
    chk("rst_bin", o4.out_bin, 0);
    chk("rst_mag_real", mre4, 0);
    chk("rst_mag_imag", mim4, 0);

    rst4 = 1'b1; rst256 = 1'b1;
    repeat (2) tick();

    // 1: full-rate frame
    d0 = dones4; b0 = beats4;
    push_frame4();
    pulse4();
    wait_done4(60, ok, b);
    chk("t1_done_seen", ok, 1);
    chk("t1_busy_at_done", b, 1);
    chk("t1_done_after_last", done4c - last4c, 1);
    chk("t1_beats_back_to_back", last4c - first4, NB - 1);
    @(negedge clk);
    chk("t1_busy_fell", busy4, 0);
    chk("t1_done_single", done4, 0);
    #1;
    chk("t1_beats", beats4 - b0, NB);
    chk("t1_dones", dones4 - d0, 1);
    chk("t1_queue_empty", q4.size(), 0);
    tick();

    // 2: stalled sink for 20 cycles
    o4.out_ready = 1'b0;
    d0 = dones4; b0 = beats4; r0 = rds4;
    push_frame4();
    pulse4();
    stable = 1'b1;
    hd = '0; hb = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 8) begin
        hd = o4.out_data;
        hb = o4.out_bin;
      end else if (i > 8) begin
        if (o4.out_data !== hd || o4.out_bin !== hb) stable = 1'b0;
      end
    end
    #1;
    chk("t2_reads_capped", rds4 - r0, (NB < FDEP) ? NB : FDEP);
    chk("t2_valid_held", o4.out_valid, 1);
    chk("t2_head_data", o4.out_data, 5);
    chk("t2_head_bin", o4.out_bin, 0);
    chk("t2_outputs_stable", stable, 1);
    chk("t2_no_done_stalled", dones4 - d0, 0);
    tick();
    o4.out_ready = 1'b1;
    wait_done4(60, ok, b);
    chk("t2_done_seen", ok, 1);
    chk("t2_beats", beats4 - b0, NB);
    chk("t2_queue_empty", q4.size(), 0);
    tick();

    // 4: start during RUN is ignored
    d0 = dones4; b0 = beats4;
    push_frame4();
    pulse4();
    pulse4();
    wait_done4(60, ok, b);
    chk("t4_done_seen", ok, 1);
    repeat (10) tick();
    chk("t4_beats", beats4 - b0, NB);
    chk("t4_dones", dones4 - d0, 1);
    chk("t4_busy_idle", busy4, 0);

    // 5: reset during DRAIN
    o4.out_ready = 1'b0;
    d0 = dones4; b0 = beats4;
    push_frame4();
    pulse4();
    repeat (10) tick();
    #2;
    rst4 = 1'b0;
    #1;
    chk("t5_busy", busy4, 0);
    chk("t5_rd_en", rd4, 0);
    chk("t5_addr", addr4, 0);
    chk("t5_valid", o4.out_valid, 0);
    chk("t5_data", o4.out_data, 0);
    chk("t5_bin", o4.out_bin, 0);
    chk("t5_last", o4.out_last, 0);
    chk("t5_mag_real", mre4, 0);
    q4.delete();
    repeat (2) tick();
    rst4 = 1'b1;
    o4.out_ready = 1'b1;
    repeat (10) tick();
    chk("t5_no_done", dones4 - d0, 0);
    chk("t5_no_beats", beats4 - b0, 0);
    b0 = beats4;
    push_frame4();
    pulse4();
    wait_done4(60, ok, b);
    chk("t5_restart_done", ok, 1);
    chk("t5_restart_beats", beats4 - b0, NB);
    chk("t5_queue_empty", q4.size(), 0);
    tick();

    // 6: start on the cycle right after done
    d0 = dones4; b0 = beats4;
    push_frame4();
    pulse4();
    wait_done4(60, ok, b);
    tick();
    push_frame4();
    pulse4();
    wait_done4(60, ok2, b);
    chk("t6_first_done", ok, 1);
    chk("t6_second_done", ok2, 1);
    chk("t6_beats", beats4 - b0, 2 * NB);
    chk("t6_dones", dones4 - d0, 2);
    chk("t6_queue_empty", q4.size(), 0);
    tick();

    // 3: 256 bins, random backpressure, 8 frames
    for (int f = 0; f < 8; f++) begin
      d0 = dones256; b0 = beats256; ok = 1'b0;
      for (int i = 0; i < NB2; i++)
        q256.push_back('{data: 32'(5 * i), bin: i, last: (i == NB2 - 1)});
      start256 = 1'b1;
      tick();
      start256 = 1'b0;
      for (int i = 0; i < 4000 && !ok; i++) begin
        o256.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (done256) ok = 1'b1;
        tick();
      end
      chk("t3_done_seen", ok, 1);
      chk("t3_beats", beats256 - b0, NB2);
      chk("t3_dones", dones256 - d0, 1);
    end
    chk("t3_queue_empty", q256.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
